// File: rtl/mem_arbiter.sv
// Two-to-one arbiter sharing one memory port between the instruction and data
// ports of the core, with one outstanding transaction and one-deep pending buffers.

package mem_arbiter_pkg;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned STRB_W = XLEN / 8;
  localparam int unsigned MODE_W = 2;

  typedef struct packed {
    logic              mem_valid;
    logic              mem_fence;
    logic              mem_spec;
    logic              mem_instr;
    logic [MODE_W-1:0] mem_mode;
    logic [XLEN-1:0]   mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic [STRB_W-1:0] mem_wstrb;
  } mem_in_type;

  typedef struct packed {
    logic [XLEN-1:0] mem_rdata;
    logic            mem_error;
    logic            mem_ready;
  } mem_out_type;
endpackage

module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter bit dmem_first = 1'b1
) (
  input  logic        reset,
  input  logic        clock,
  input  mem_in_type  imem_in,
  output mem_out_type imem_out,
  input  mem_in_type  dmem_in,
  output mem_out_type dmem_out,
  output mem_in_type  memory_in,
  input  mem_out_type memory_out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t     state, state_n;
  logic       pend_i_vld, pend_d_vld;
  mem_in_type pend_i, pend_d;
  logic       cap_i, cap_d, clr_i, clr_d;

  // State register and pending buffers; a capture wins over a same-cycle clear.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      pend_i_vld <= 1'b0;
      pend_d_vld <= 1'b0;
      pend_i     <= '0;
      pend_d     <= '0;
    end else begin
      state      <= state_n;
      pend_i_vld <= (pend_i_vld & ~clr_i) | cap_i;
      pend_d_vld <= (pend_d_vld & ~clr_d) | cap_d;
      if (cap_i) pend_i <= imem_in;
      if (cap_d) pend_d <= dmem_in;
    end
  end

  // Issue, capture and response routing.
  always_comb begin
    state_n   = state;
    memory_in = '0;
    imem_out  = '0;
    dmem_out  = '0;
    cap_i     = 1'b0;
    cap_d     = 1'b0;
    clr_i     = 1'b0;
    clr_d     = 1'b0;

    case (state)
      IDLE: begin
        if (pend_i_vld) begin
          memory_in = pend_i;
          clr_i     = 1'b1;
          state_n   = BUSY_I;
          cap_i     = imem_in.mem_valid;
          cap_d     = dmem_in.mem_valid & ~pend_d_vld;
        end else if (pend_d_vld) begin
          memory_in = pend_d;
          clr_d     = 1'b1;
          state_n   = BUSY_D;
          cap_i     = imem_in.mem_valid;
          cap_d     = dmem_in.mem_valid;
        end else if (imem_in.mem_valid && dmem_in.mem_valid) begin
          if (dmem_first) begin
            memory_in = dmem_in;
            state_n   = BUSY_D;
            cap_i     = 1'b1;
          end else begin
            memory_in = imem_in;
            state_n   = BUSY_I;
            cap_d     = 1'b1;
          end
        end else if (imem_in.mem_valid) begin
          memory_in = imem_in;
          state_n   = BUSY_I;
        end else if (dmem_in.mem_valid) begin
          memory_in = dmem_in;
          state_n   = BUSY_D;
        end
      end

      BUSY_I: begin
        cap_d = dmem_in.mem_valid & ~pend_d_vld;
        // A set owner buffer here means the request still has to go out.
        if (pend_i_vld) begin
          memory_in = pend_i;
          clr_i     = 1'b1;
        end else begin
          imem_out = memory_out;
          if (memory_out.mem_ready) begin
            cap_i = imem_in.mem_valid;
            if (cap_i)                    state_n = BUSY_I;
            else if (pend_d_vld || cap_d) state_n = BUSY_D;
            else                          state_n = IDLE;
          end
        end
      end

      BUSY_D: begin
        cap_i = imem_in.mem_valid & ~pend_i_vld;
        if (pend_d_vld) begin
          memory_in = pend_d;
          clr_d     = 1'b1;
        end else begin
          dmem_out = memory_out;
          if (memory_out.mem_ready) begin
            cap_d = dmem_in.mem_valid;
            if (pend_i_vld || cap_i) state_n = BUSY_I;
            else if (cap_d)          state_n = BUSY_D;
            else                     state_n = IDLE;
          end
        end
      end

      default: state_n = IDLE;
    endcase

    // Reset blanks every output, including a response still in flight.
    if (!reset) begin
      memory_in = '0;
      imem_out  = '0;
      dmem_out  = '0;
      cap_i     = 1'b0;
      cap_d     = 1'b0;
      state_n   = IDLE;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Cycle-vector bench for mem_arbiter: each row drives one cycle and its expected
// outputs go through a scoreboard queue to be compared mid-cycle.

module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  mem_in_type  imem_in, dmem_in, mi1, mi0;
  mem_out_type memory_out, io1, do1, io0, do0;

  always #5 clock = ~clock;

  mem_arbiter #(.dmem_first(1'b1)) dut (
    .reset(reset), .clock(clock),
    .imem_in(imem_in), .imem_out(io1),
    .dmem_in(dmem_in), .dmem_out(do1),
    .memory_in(mi1), .memory_out(memory_out)
  );

  mem_arbiter #(.dmem_first(1'b0)) dut_ifirst (
    .reset(reset), .clock(clock),
    .imem_in(imem_in), .imem_out(io0),
    .dmem_in(dmem_in), .dmem_out(do0),
    .memory_in(mi0), .memory_out(memory_out)
  );

  typedef struct packed {
    logic        mv;
    logic        mf;
    logic [31:0] ma;
    logic [31:0] mwd;
    logic [3:0]  mws;
    logic        ir;
    logic [31:0] ird;
    logic        ie;
    logic        dr;
    logic [31:0] drd;
    logic        de;
  } obs_t;

  typedef struct {
    logic        rst;
    logic        iv;
    logic [31:0] ia;
    logic        dv;
    logic        df;
    logic [31:0] da;
    logic [31:0] dwd;
    logic [3:0]  dws;
    logic        mr;
    logic [31:0] mrd;
    logic        me;
    obs_t        exp;
  } vec_t;

  obs_t sb_q[$];
  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t v(
    input logic rst, input logic iv, input logic [31:0] ia,
    input logic dv, input logic df, input logic [31:0] da,
    input logic [31:0] dwd, input logic [3:0] dws,
    input logic mr, input logic [31:0] mrd, input logic me,
    input logic mv, input logic mf, input logic [31:0] ma,
    input logic [31:0] mwd, input logic [3:0] mws,
    input logic ir, input logic [31:0] ird,
    input logic dr, input logic [31:0] drd, input logic de);
    vec_t r;
    r.rst = rst; r.iv = iv; r.ia = ia; r.dv = dv; r.df = df; r.da = da;
    r.dwd = dwd; r.dws = dws; r.mr = mr; r.mrd = mrd; r.me = me;
    r.exp.mv = mv; r.exp.mf = mf; r.exp.ma = ma; r.exp.mwd = mwd;
    r.exp.mws = mws; r.exp.ir = ir; r.exp.ird = ird; r.exp.ie = 1'b0;
    r.exp.dr = dr; r.exp.drd = drd; r.exp.de = de;
    return r;
  endfunction

  function automatic obs_t sample(input mem_in_type m, input mem_out_type io,
                                  input mem_out_type dout);
    obs_t o;
    o.mv = m.mem_valid; o.mf = m.mem_fence; o.ma = m.mem_addr;
    o.mwd = m.mem_wdata; o.mws = m.mem_wstrb;
    o.ir = io.mem_ready; o.ird = io.mem_rdata; o.ie = io.mem_error;
    o.dr = dout.mem_ready; o.drd = dout.mem_rdata; o.de = dout.mem_error;
    return o;
  endfunction

  // Drive one cycle, queue its expectation, compare at the falling edge.
  task automatic step(input vec_t x, input bit use0, input string name);
    obs_t act, want;
    reset                = x.rst;
    imem_in              = '0;
    imem_in.mem_valid    = x.iv;
    imem_in.mem_instr    = x.iv;
    imem_in.mem_addr     = x.ia;
    dmem_in              = '0;
    dmem_in.mem_valid    = x.dv;
    dmem_in.mem_fence    = x.df;
    dmem_in.mem_addr     = x.da;
    dmem_in.mem_wdata    = x.dwd;
    dmem_in.mem_wstrb    = x.dws;
    memory_out.mem_ready = x.mr;
    memory_out.mem_rdata = x.mrd;
    memory_out.mem_error = x.me;
    sb_q.push_back(x.exp);
    @(negedge clock);
    act  = use0 ? sample(mi0, io0, do0) : sample(mi1, io1, do1);
    want = sb_q.pop_front();
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, act, want);
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset      = 1'b0;
    imem_in    = '0;
    dmem_in    = '0;
    memory_out = '0;

    // rst iv ia dv df da dwd dws mr mrd me | mv mf ma mwd mws ir ird dr drd de
    tbl.push_back(v('0,'0,'0,'0,'0,'0,'0,4'h0,'1,32'h55,'0, '0,'0,'0,'0,4'h0,'0,'0,'0,'0,'0));
    tbl.push_back(v('0,'0,'0,'0,'0,'0,'0,4'h0,'0,'0,'0, '0,'0,'0,'0,4'h0,'0,'0,'0,'0,'0));
    tbl.push_back(v('1,'1,32'h100,'0,'0,'0,'0,4'h0,'0,'0,'0, '1,'0,32'h100,'0,4'h0,'0,'0,'0,'0,'0));
    tbl.push_back(v('1,'0,'0,'0,'0,'0,'0,4'h0,'0,'0,'0, '0,'0,'0,'0,4'h0,'0,'0,'0,'0,'0));
    tbl.push_back(v('1,'0,'0,'0,'0,'0,'0,4'h0,'1,32'h13,'0, '0,'0,'0,'0,4'h0,'1,32'h13,'0,'0,'0));
    tbl.push_back(v('1,'1,32'h100,'1,'0,32'h2000,'0,4'h0,'0,'0,'0, '1,'0,32'h2000,'0,4'h0,'0,'0,'0,'0,'0));
    tbl.push_back(v('1,'0,'0,'0,'0,'0,'0,4'h0,'0,'0,'0, '0,'0,'0,'0,4'h0,'0,'0,'0,'0,'0));
    tbl.push_back(v('1,'0,'0,'0,'0,'0,'0,4'h0,'1,32'hAAAA,'0, '0,'0,'0,'0,4'h0,'0,'0,'1,32'hAAAA,'0));
    tbl.push_back(v('1,'0,'0,'0,'0,'0,'0,4'h0,'0,'0,'0, '1,'0,32'h100,'0,4'h0,'0,'0,'0,'0,'0));
    tbl.push_back(v('1,'0,'0,'0,'0,'0,'0,4'h0,'1,32'h13,'0, '0,'0,'0,'0,4'h0,'1,32'h13,'0,'0,'0));
    tbl.push_back(v('1,'1,32'h200,'0,'0,'0,'0,4'h0,'0,'0,'0, '1,'0,32'h200,'0,4'h0,'0,'0,'0,'0,'0));
    tbl.push_back(v('1,'0,'0,'1,'0,32'h2004,32'hDEADBEEF,4'hF,'0,'0,'0, '0,'0,'0,'0,4'h0,'0,'0,'0,'0,'0));
    tbl.push_back(v('1,'0,'0,'0,'0,'0,'0,4'h0,'1,32'h77,'0, '0,'0,'0,'0,4'h0,'1,32'h77,'0,'0,'0));
    tbl.push_back(v('1,'0,'0,'0,'0,'0,'0,4'h0,'0,'0,'0, '1,'0,32'h2004,32'hDEADBEEF,4'hF,'0,'0,'0,'0,'0));
    tbl.push_back(v('1,'0,'0,'0,'0,'0,'0,4'h0,'1,'0,'1, '0,'0,'0,'0,4'h0,'0,'0,'1,'0,'1));
    tbl.push_back(v('1,'0,'0,'1,'0,32'h3000,'0,4'h0,'0,'0,'0, '1,'0,32'h3000,'0,4'h0,'0,'0,'0,'0,'0));
    tbl.push_back(v('1,'0,'0,'1,'0,32'h3004,'0,4'h0,'0,'0,'0, '0,'0,'0,'0,4'h0,'0,'0,'0,'0,'0));
    tbl.push_back(v('1,'0,'0,'1,'0,32'h3008,'0,4'h0,'1,32'h1,'0, '0,'0,'0,'0,4'h0,'0,'0,'1,32'h1,'0));
    tbl.push_back(v('1,'0,'0,'0,'0,'0,'0,4'h0,'0,'0,'0, '1,'0,32'h3008,'0,4'h0,'0,'0,'0,'0,'0));
    tbl.push_back(v('1,'0,'0,'0,'0,'0,'0,4'h0,'1,32'h2,'0, '0,'0,'0,'0,4'h0,'0,'0,'1,32'h2,'0));
    tbl.push_back(v('1,'0,'0,'0,'0,'0,'0,4'h0,'1,32'h99,'0, '0,'0,'0,'0,4'h0,'0,'0,'0,'0,'0));
    tbl.push_back(v('1,'1,32'h100,'1,'0,32'h2000,'0,4'h0,'0,'0,'0, '1,'0,32'h2000,'0,4'h0,'0,'0,'0,'0,'0));
    tbl.push_back(v('0,'0,'0,'0,'0,'0,'0,4'h0,'1,32'h5,'0, '0,'0,'0,'0,4'h0,'0,'0,'0,'0,'0));
    tbl.push_back(v('1,'0,'0,'0,'0,'0,'0,4'h0,'0,'0,'0, '0,'0,'0,'0,4'h0,'0,'0,'0,'0,'0));
    tbl.push_back(v('1,'0,'0,'0,'0,'0,'0,4'h0,'1,32'h5,'0, '0,'0,'0,'0,4'h0,'0,'0,'0,'0,'0));
    tbl.push_back(v('1,'0,'0,'0,'0,'0,'0,4'h0,'0,'0,'0, '0,'0,'0,'0,4'h0,'0,'0,'0,'0,'0));
    tbl.push_back(v('1,'0,'0,'1,'1,32'h40,'0,4'h0,'0,'0,'0, '1,'1,32'h40,'0,4'h0,'0,'0,'0,'0,'0));
    tbl.push_back(v('1,'0,'0,'0,'0,'0,'0,4'h0,'1,32'h8,'0, '0,'0,'0,'0,4'h0,'0,'0,'1,32'h8,'0));

    @(posedge clock);
    #1;
    for (int i = 0; i < tbl.size(); i++) step(tbl[i], 1'b0, $sformatf("row%0d", i));

    // Instruction-first variant: the fetch wins and the load waits in its buffer.
    step(v('0,'0,'0,'0,'0,'0,'0,4'h0,'0,'0,'0, '0,'0,'0,'0,4'h0,'0,'0,'0,'0,'0), 1'b1, "ifirst_rst");
    step(v('1,'1,32'h100,'1,'0,32'h2000,'0,4'h0,'0,'0,'0, '1,'0,32'h100,'0,4'h0,'0,'0,'0,'0,'0), 1'b1, "ifirst_issue");
    step(v('1,'0,'0,'0,'0,'0,'0,4'h0,'0,'0,'0, '0,'0,'0,'0,4'h0,'0,'0,'0,'0,'0), 1'b1, "ifirst_wait");
    step(v('1,'0,'0,'0,'0,'0,'0,4'h0,'1,32'h13,'0, '0,'0,'0,'0,4'h0,'1,32'h13,'0,'0,'0), 1'b1, "ifirst_iresp");
    step(v('1,'0,'0,'0,'0,'0,'0,4'h0,'0,'0,'0, '1,'0,32'h2000,'0,4'h0,'0,'0,'0,'0,'0), 1'b1, "ifirst_dissue");
    step(v('1,'0,'0,'0,'0,'0,'0,4'h0,'1,32'h44,'0, '0,'0,'0,'0,4'h0,'0,'0,'1,32'h44,'0), 1'b1, "ifirst_dresp");

    // Both buffers full at a ready: the fetch goes out before the second load.
    step(v('0,'0,'0,'0,'0,'0,'0,4'h0,'0,'0,'0, '0,'0,'0,'0,4'h0,'0,'0,'0,'0,'0), 1'b0, "both_rst");
    step(v('1,'1,32'h100,'1,'0,32'h2000,'0,4'h0,'0,'0,'0, '1,'0,32'h2000,'0,4'h0,'0,'0,'0,'0,'0), 1'b0, "both_issue");
    step(v('1,'0,'0,'1,'0,32'h2008,'0,4'h0,'1,32'h11,'0, '0,'0,'0,'0,4'h0,'0,'0,'1,32'h11,'0), 1'b0, "both_dresp");
    step(v('1,'0,'0,'0,'0,'0,'0,4'h0,'0,'0,'0, '1,'0,32'h100,'0,4'h0,'0,'0,'0,'0,'0), 1'b0, "both_iissue");
    step(v('1,'0,'0,'0,'0,'0,'0,4'h0,'1,32'h22,'0, '0,'0,'0,'0,4'h0,'1,32'h22,'0,'0,'0), 1'b0, "both_iresp");
    step(v('1,'0,'0,'0,'0,'0,'0,4'h0,'0,'0,'0, '1,'0,32'h2008,'0,4'h0,'0,'0,'0,'0,'0), 1'b0, "both_dissue");
    step(v('1,'0,'0,'0,'0,'0,'0,4'h0,'1,32'h33,'0, '0,'0,'0,'0,4'h0,'0,'0,'1,32'h33,'0), 1'b0, "both_dresp2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
